// File: rtl/rom_burst_reader_pkg.sv
// rom_burst_reader_pkg
//   Shared types and helpers for the ROM burst reader slice.
//   - state_t        : FSM states (IDLE, BURST)
//   - ROM_RD_LATENCY : cycles from beat issue to readdatavalid
//   - norm_bc()      : burstcount normalisation (0 is treated as 1)
package rom_burst_reader_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int ROM_RD_LATENCY = 2;

  // Burstcount 0 is treated as a single beat.
  function automatic logic [31:0] norm_bc(input logic [31:0] bc);
    return (bc == 32'd0) ? 32'd1 : bc;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if
//   Avalon-MM read-only bus plus the ROM address/data pair.
//   master : interconnect side (drives address/read/burstcount)
//   slave  : the reader (drives waitrequest/readdata/readdatavalid, rom_addr)
//   rom_q is driven by the ROM instance and consumed by the slave.
interface rom_burst_reader_if #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10,
  parameter int BURSTW  = 4
);
  logic [WIDTHAD-1:0] avs_address;
  logic               avs_read;
  logic [BURSTW-1:0]  avs_burstcount;
  logic               avs_waitrequest;
  logic [WIDTH-1:0]   avs_readdata;
  logic               avs_readdatavalid;
  logic [WIDTHAD-1:0] rom_addr;
  logic [WIDTH-1:0]   rom_q;

  modport master (
    output avs_address, avs_read, avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_burstcount, rom_q,
    output avs_waitrequest, avs_readdata, avs_readdatavalid, rom_addr
  );
endinterface

// File: rtl/rom_addr_gen.sv
// rom_addr_gen
//   Burst address generator: address register, remaining-beat counter and
//   increment logic. Linear increment by default; with ROM_WRAP_BURST_EN
//   defined, bursts wrap inside the burstcount-aligned block via a mask
//   register loaded at accept.
//   Ports:
//     clk, rst    : clock, async active-high reset
//     load        : accept of a multi-beat burst (first beat issued directly)
//     step        : a BURST-state beat is issued this cycle
//     sel_reg     : drive rom_addr from the address register (BURST state)
//     start_addr  : avs_address of the command
//     bcnt        : normalised burstcount
//     rom_addr    : address presented to the ROM
//     last_beat   : the beat issued this cycle is the final one
//     busy        : beats remain to be issued from the register
module rom_addr_gen #(
  parameter int WIDTHAD = 10,
  parameter int BURSTW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               sel_reg,
  input  logic [WIDTHAD-1:0] start_addr,
  input  logic [BURSTW-1:0]  bcnt,
  output logic [WIDTHAD-1:0] rom_addr,
  output logic               last_beat,
  output logic               busy
);

  logic [WIDTHAD-1:0] addr_q;
  logic [BURSTW-1:0]  rem_q;

`ifdef ROM_WRAP_BURST_EN
  logic [WIDTHAD-1:0] mask_q, mask_d;

  // Power-of-two burstcount gives a mask covering the low log2(bc) bits.
  assign mask_d = WIDTHAD'(bcnt) - WIDTHAD'(1);

  function automatic logic [WIDTHAD-1:0] inc(input logic [WIDTHAD-1:0] a,
                                             input logic [WIDTHAD-1:0] m);
    return (a & ~m) | ((a + WIDTHAD'(1)) & m);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mask_q <= '0;
    else if (load) mask_q <= mask_d;
  end
`else
  function automatic logic [WIDTHAD-1:0] inc(input logic [WIDTHAD-1:0] a);
    return a + WIDTHAD'(1);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
`ifdef ROM_WRAP_BURST_EN
      addr_q <= inc(start_addr, mask_d);
`else
      addr_q <= inc(start_addr);
`endif
      rem_q  <= bcnt - BURSTW'(1);
    end else if (step && busy) begin
`ifdef ROM_WRAP_BURST_EN
      addr_q <= inc(addr_q, mask_q);
`else
      addr_q <= inc(addr_q);
`endif
      rem_q  <= rem_q - BURSTW'(1);
    end
  end

  assign rom_addr  = sel_reg ? addr_q : start_addr;
  assign busy      = (rem_q != '0);
  assign last_beat = (rem_q == BURSTW'(1));

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Avalon-MM read-only slave in front of a synchronous ROM with a
//   registered address. Issues one ROM address per cycle and returns
//   data two cycles later with readdatavalid.
//   Optional: ROM_WRAP_BURST_EN selects wrapping (cache-line) bursts.
//   Ports:
//     clk, rst : clock, async active-high reset
//     bus      : rom_burst_reader_if.slave (Avalon-MM + ROM addr/q)
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10,
  parameter int BURSTW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rom_burst_reader_if.slave      bus
);

  state_t state_q, state_d;
  logic   issue, load, step, last_beat, busy, waitreq;
  logic [BURSTW-1:0]         bc_eff;
  logic [ROM_RD_LATENCY-1:0] vld_pipe;  // [0]=issue_v (rom_q valid), [1]=rd_v
  logic [WIDTH-1:0]          rdata_q;

  assign bc_eff = BURSTW'(norm_bc(32'(bus.avs_burstcount)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    waitreq = 1'b0;
    issue   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.avs_read) begin
          issue = 1'b1;
          if (bc_eff > BURSTW'(1)) begin
            load    = 1'b1;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        waitreq = 1'b1;
        issue   = busy;
        step    = 1'b1;
        if (last_beat || !busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rom_addr_gen #(.WIDTHAD(WIDTHAD), .BURSTW(BURSTW)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .sel_reg    (state_q == BURST),
    .start_addr (bus.avs_address),
    .bcnt       (bc_eff),
    .rom_addr   (bus.rom_addr),
    .last_beat  (last_beat),
    .busy       (busy)
  );

  // Reset clears the pipe, so beats in flight never produce a valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[ROM_RD_LATENCY-2:0], issue};
  end

  // Capture rom_q only for issued beats; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rdata_q <= '0;
    else if (vld_pipe[0]) rdata_q <= bus.rom_q;
  end

  assign bus.avs_waitrequest   = waitreq;
  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = vld_pipe[ROM_RD_LATENCY-1];

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader
//   Directed bench for rom_burst_reader with a registered ROM model.
//   Define ROM_WRAP_BURST_EN to exercise wrapping bursts.
module tb_rom_burst_reader;

  localparam int WIDTH = 32, WIDTHAD = 10, BURSTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTHAD-1:0] exp_a [8];

  always #5 clk = ~clk;

  rom_burst_reader_if #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD), .BURSTW(BURSTW)) bus ();

  rom_burst_reader #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD), .BURSTW(BURSTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_f(input logic [WIDTHAD-1:0] a);
    return {a[7:0] ^ 8'h5A, 6'h0, a, 8'hC3};
  endfunction

  // Synchronous ROM: address registered, data one cycle later.
  always_ff @(posedge clk) bus.rom_q <= mem_f(bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command in the current cycle; n = effective beats, expected
  // addresses in exp_a. Optionally chain a single read at nxt in the
  // cycle the burst returns to IDLE.
  task automatic run_burst(input logic [WIDTHAD-1:0] a, input logic [BURSTW-1:0] bc,
                           input int n, input bit chain, input logic [WIDTHAD-1:0] nxt);
    bus.avs_read = 1'b1; bus.avs_address = a; bus.avs_burstcount = bc;
    #1;
    chk("accept_addr", 32'(bus.rom_addr), 32'(a));
    chk("accept_wait", 32'(bus.avs_waitrequest), 32'd0);
    for (int k = 1; k <= n + 2; k++) begin
      step();
      if (k == 1) bus.avs_read = 1'b0;
      if (k == n + 1) bus.avs_read = 1'b0;
      if (chain && k == n) begin
        bus.avs_read = 1'b1; bus.avs_address = nxt; bus.avs_burstcount = 4'd1;
      end
      #1;
      chk($sformatf("wait_k%0d", k), 32'(bus.avs_waitrequest), (k < n) ? 32'd1 : 32'd0);
      if (k < n) chk($sformatf("addr_k%0d", k), 32'(bus.rom_addr), 32'(exp_a[k]));
      if (k >= 2 && k <= n + 1) begin
        chk($sformatf("vld_k%0d", k), 32'(bus.avs_readdatavalid), 32'd1);
        chk($sformatf("data_k%0d", k), bus.avs_readdata, mem_f(exp_a[k-2]));
      end else if (k == n + 2) begin
        chk("tail_vld", 32'(bus.avs_readdatavalid), chain ? 32'd1 : 32'd0);
        if (chain) chk("tail_data", bus.avs_readdata, mem_f(nxt));
      end else begin
        chk($sformatf("vld_k%0d", k), 32'(bus.avs_readdatavalid), 32'd0);
      end
    end
    step();
    chk("idle_vld", 32'(bus.avs_readdatavalid), 32'd0);
  endtask

  initial begin
    bus.avs_read = 1'b0; bus.avs_address = '0; bus.avs_burstcount = '0;
    #1;
    chk("rst_vld",  32'(bus.avs_readdatavalid), 32'd0);
    chk("rst_data", bus.avs_readdata, 32'd0);
    chk("rst_wait", 32'(bus.avs_waitrequest), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single read at 0x005, then readdata must hold.
    exp_a[0] = 10'h005;
    run_burst(10'h005, 4'd1, 1, 1'b0, '0);
    chk("hold_data", bus.avs_readdata, mem_f(10'h005));

    // Burst 4 at 0x010 followed immediately by a single at 0x030.
    exp_a[0] = 10'h010; exp_a[1] = 10'h011; exp_a[2] = 10'h012; exp_a[3] = 10'h013;
    run_burst(10'h010, 4'd4, 4, 1'b1, 10'h030);

    // Linear burst across the top of the address space.
`ifndef ROM_WRAP_BURST_EN
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    run_burst(10'h3FE, 4'd4, 4, 1'b0, '0);
`else
    exp_a[0] = 10'h012; exp_a[1] = 10'h013; exp_a[2] = 10'h010; exp_a[3] = 10'h011;
    run_burst(10'h012, 4'd4, 4, 1'b0, '0);
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h3FC; exp_a[3] = 10'h3FD;
    run_burst(10'h3FE, 4'd4, 4, 1'b0, '0);
`endif

    // Burstcount 0 behaves as a single beat.
    exp_a[0] = 10'h0AB;
    run_burst(10'h0AB, 4'd0, 1, 1'b0, '0);

    // Back-to-back singles at 0x020, 0x021, 0x022.
    bus.avs_read = 1'b1; bus.avs_burstcount = 4'd1; bus.avs_address = 10'h020;
    step(); bus.avs_address = 10'h021; #1;
    chk("b2b_v1", 32'(bus.avs_readdatavalid), 32'd0);
    chk("b2b_w1", 32'(bus.avs_waitrequest), 32'd0);
    step(); bus.avs_address = 10'h022; #1;
    chk("b2b_v2", 32'(bus.avs_readdatavalid), 32'd1);
    chk("b2b_d2", bus.avs_readdata, mem_f(10'h020));
    step(); bus.avs_read = 1'b0; #1;
    chk("b2b_v3", 32'(bus.avs_readdatavalid), 32'd1);
    chk("b2b_d3", bus.avs_readdata, mem_f(10'h021));
    step();
    chk("b2b_v4", 32'(bus.avs_readdatavalid), 32'd1);
    chk("b2b_d4", bus.avs_readdata, mem_f(10'h022));
    step();
    chk("b2b_v5", 32'(bus.avs_readdatavalid), 32'd0);

    // Burst 8 at 0x040 with reset pulsed in cycle 3.
    bus.avs_read = 1'b1; bus.avs_address = 10'h040; bus.avs_burstcount = 4'd8;
    step(); bus.avs_read = 1'b0; #1;
    chk("r8_w1", 32'(bus.avs_waitrequest), 32'd1);
    step();
    chk("r8_v2", 32'(bus.avs_readdatavalid), 32'd1);
    chk("r8_d2", bus.avs_readdata, mem_f(10'h040));
    step();
    rst = 1'b1; #1;
    chk("r8_rst_v", 32'(bus.avs_readdatavalid), 32'd0);
    chk("r8_rst_w", 32'(bus.avs_waitrequest), 32'd0);
    chk("r8_rst_d", bus.avs_readdata, 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("r8_post_v%0d", k), 32'(bus.avs_readdatavalid), 32'd0);
      chk($sformatf("r8_post_w%0d", k), 32'(bus.avs_waitrequest), 32'd0);
    end
    exp_a[0] = 10'h007;
    run_burst(10'h007, 4'd1, 1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Avalon-MM read-only slave front end for a synchronous single-port ROM whose address is registered inside the ROM, so data appears one cycle after the address is sampled.
- Sits between the system interconnect (BIOS/VGA-BIOS ROM window) and the ROM instance.
- Accepts single or burst reads, streams the ROM address, and returns registered data with readdatavalid at one beat per cycle.

Parameters:
- WIDTH, 32, ROM word / readdata width.
- WIDTHAD, 10, ROM word-address width; ROM depth is 2**WIDTHAD.
- BURSTW, 4, avs_burstcount width; maximum burst is 2**(BURSTW-1) beats.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- avs_address  in  WIDTHAD  word address of the first beat.
- avs_read  in  1  read request.
- avs_burstcount  in  BURSTW  number of beats; 0 is treated as 1.
- avs_waitrequest  out  1  high while a multi-beat burst is still issuing.
- avs_readdata  out  WIDTH  returned ROM word, registered.
- avs_readdatavalid  out  1  one pulse per returned beat.
- rom_addr  out  WIDTHAD  address to the ROM; sampled by the ROM on posedge clk.
- rom_q  in  WIDTH  ROM data for the address sampled on the previous edge.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, beat counter=0, address register=0.
  - avs_readdatavalid=0 and avs_readdata=0 immediately.
  - avs_waitrequest=0.
  - Beats in flight are discarded, with no valid pulse after reset release.
- States: IDLE and BURST.
- IDLE:
  - avs_waitrequest=0; rom_addr = avs_address (combinational).
  - A command is accepted when avs_read=1.
  - The first beat is issued in the accept cycle.
  - If effective burstcount > 1: load address register = avs_address+1 and remaining = burstcount-1, then go to BURST.
  - Otherwise stay in IDLE, so a new single read can be accepted every cycle.
- BURST:
  - avs_waitrequest=1; rom_addr = address register.
  - Each cycle: issue one beat, address+1, remaining-1.
  - When the beat with remaining==1 is issued, return to IDLE next cycle; waitrequest drops that cycle.
- Issue pipeline:
  - A beat issued in cycle t is sampled by the ROM at the end of t.
  - rom_q is valid in t+1 and is registered into avs_readdata at the end of t+1.
  - avs_readdatavalid=1 during t+2.
  - Fixed latency: 2 cycles from issue to valid. Throughput: 1 beat/cycle.
- Issue tracking: a 2-stage valid shift register (issue_v -> rd_v) marks issued beats. No other buffering; the slave never stalls return data.
- Address arithmetic: increment is modulo 2**WIDTHAD, so 2**WIDTHAD-1 wraps to 0.
- avs_read is ignored while in BURST; the interconnect holds it under waitrequest.
- A burst ending followed by a new command accepted the next cycle gives continuous readdatavalid with no gap.
- avs_readdata holds its last value when avs_readdatavalid=0.

Optional Feature:
- Macro: ROM_WRAP_BURST_EN.
- Defined:
  - Bursts are wrapping (cache-line fill).
  - Burstcount must be a power of two.
  - The address increments only within the burstcount-aligned block: low log2(burstcount) bits wrap, upper bits are held.
  - A wrap mask register is loaded at accept.
- Undefined: bursts are linear (incrementing) as described in Behaviour, and no mask logic is present.

Decomposition:
- Package rom_burst_reader_pkg:
  - state enum (IDLE, BURST);
  - latency constant ROM_RD_LATENCY=2;
  - function for burstcount normalisation (0 -> 1).
- Sub-module rom_addr_gen:
  - address register, remaining-beat counter, linear or wrap increment (with the ROM_WRAP_BURST_EN mask).
  - outputs rom_addr, last_beat and busy.
- Top level holds the FSM and the valid/data pipeline.

Test Plan:
- Single read of address 0x005 in cycle 10 -> rom_addr=0x005 in cycle 10; avs_readdatavalid=1 in cycle 12 only; avs_readdata=mem[5]; waitrequest stays 0.
- Burst address 0x010, burstcount 4, accepted in cycle 0 -> waitrequest=1 in cycles 1-3 and 0 in cycle 4; valid in cycles 2-5 with mem[0x10..0x13].
- Linear burst at address 0x3FE, burstcount 4 (WIDTHAD=10) -> data mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001].
- Back-to-back single reads at 0x020, 0x021, 0x022 in consecutive cycles -> three consecutive valid cycles with the matching data.
- Burst of 8 at 0x040, rst asserted in cycle 3 for 1 cycle -> readdatavalid=0 from the rst edge onward, no further pulses, waitrequest=0, next read after release returns correct data.
- With ROM_WRAP_BURST_EN: burst 4 at 0x012 -> data mem[0x12], mem[0x13], mem[0x10], mem[0x11].
- With ROM_WRAP_BURST_EN: burstcount 0 -> single beat.
